// File: rtl/pc_sequencer.sv
// Program-counter sequencer: IDLE -> FETCH -> UPDATE loop. Next-PC arithmetic
// is delegated to an external combinational 16-bit adder.
module pc_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_INC   = 16'h0002
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        halt,
  input  logic        stall,
  input  logic        memReady,
  input  logic        jump,
  input  logic [15:0] jumpTarget,
  input  logic        branchTaken,
  input  logic [15:0] branchOffset,
  input  logic [15:0] adderSum,
  output logic [15:0] adderA,
  output logic [15:0] adderB,
  output logic [15:0] pcOut,
  output logic        fetchReq,
  output logic        instrValid,
  output logic [1:0]  state
);

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] FETCH  = 2'b01;
  localparam logic [1:0] UPDATE = 2'b10;

  logic [1:0]  state_q, state_d;
  logic [15:0] pc_q, pc_d;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      IDLE: begin
        if (start && !halt) state_d = FETCH;
      end
      FETCH: begin
        // halt abandons the fetch even if memory acknowledges this cycle
        if (halt)          state_d = IDLE;
        else if (memReady) state_d = UPDATE;
      end
      UPDATE: begin
        if (halt) begin
          state_d = IDLE;
        end else if (stall) begin
          state_d = UPDATE;
        end else if (jump) begin
          pc_d    = jumpTarget;
          state_d = FETCH;
        end else begin
          pc_d    = adderSum;
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Outputs decode from the registered state so reset clears them at once.
  assign fetchReq   = (state_q == FETCH);
  assign instrValid = (state_q == FETCH) && memReady && !halt;
  assign pcOut      = pc_q;
  assign state      = state_q;
  assign adderA     = pc_q;
  assign adderB     = ((state_q == UPDATE) && branchTaken) ? branchOffset : PC_INC;

endmodule
